// File: rtl/pw_trigger_gen.sv
// pw_trigger_gen: front-end trigger sequencer (fe_clk domain).
// On an accepted pattern match, emits a train of up to pNUM_TRIGGER_PULSES
// trigger pulses (each with its own delay/width) and, independently, a
// single-cycle capture-enable pulse after a programmable capture delay.
// Optional build macro: PW_TRIG_MATCH_COUNT_EN adds saturating accepted /
// dropped match counters (O_match_count, O_match_dropped).
module pw_trigger_gen #(
  parameter int pNUM_TRIGGER_PULSES  = 8,
  parameter int pNUM_TRIGGER_WIDTH   = 4,
  parameter int pDELAY_WIDTH         = 24,
  parameter int pWIDTH_WIDTH         = 24,
  parameter int pCAPTURE_DELAY_WIDTH = 18
) (
  input  logic                                         fe_clk,
  input  logic                                         reset_n,
  input  logic                                         I_arm,
  input  logic                                         I_trigger_enable,
  input  logic                                         I_match,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]                I_num_triggers,
  input  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0]  I_trigger_delay,
  input  logic [pWIDTH_WIDTH*pNUM_TRIGGER_PULSES-1:0]  I_trigger_width,
  input  logic [pCAPTURE_DELAY_WIDTH-1:0]              I_capture_delay,
  output logic                                         O_trigger,
  output logic                                         O_capture_enable_pulse,
  output logic                                         O_busy,
  output logic [pNUM_TRIGGER_WIDTH-1:0]                O_pulse_index
`ifdef PW_TRIG_MATCH_COUNT_EN
  ,
  output logic [15:0]                                  O_match_count,
  output logic [15:0]                                  O_match_dropped
`endif
);

  localparam int CNT_W = (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;
  localparam int IW    = pNUM_TRIGGER_WIDTH;
  localparam int CW    = pCAPTURE_DELAY_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;

  localparam logic [IW-1:0]    IDX_ONE    = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CAP_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [IW:0]      MAX_PULSES = (IW+1)'(pNUM_TRIGGER_PULSES);
  localparam logic [IW-1:0]    MAX_LAST   = IW'(pNUM_TRIGGER_PULSES - 1);

  // Select delay entry idx from a packed delay vector.
  function automatic logic [pDELAY_WIDTH-1:0] sel_delay(
    input logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0] vec, input logic [IW-1:0] idx);
    sel_delay = '0;
    for (int k = 0; k < pNUM_TRIGGER_PULSES; k++)
      if (idx == k[IW-1:0]) sel_delay = vec[k*pDELAY_WIDTH +: pDELAY_WIDTH];
  endfunction

  // Select width entry idx from a packed width vector.
  function automatic logic [pWIDTH_WIDTH-1:0] sel_width(
    input logic [pWIDTH_WIDTH*pNUM_TRIGGER_PULSES-1:0] vec, input logic [IW-1:0] idx);
    sel_width = '0;
    for (int k = 0; k < pNUM_TRIGGER_PULSES; k++)
      if (idx == k[IW-1:0]) sel_width = vec[k*pWIDTH_WIDTH +: pWIDTH_WIDTH];
  endfunction

  // max(v,1)-1: a zero field still lasts one cycle.
  function automatic logic [CNT_W-1:0] floor_m1(input logic [CNT_W-1:0] v);
    floor_m1 = (v == '0) ? '0 : (v - CNT_ONE);
  endfunction

  logic [1:0]                                  state_q, state_d;
  logic [CNT_W-1:0]                            cnt_q, cnt_d;
  logic [IW-1:0]                               idx_q, idx_d;
  logic [IW-1:0]                               num_last_q, num_last_d;
  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0] dly_q, dly_d;
  logic [pWIDTH_WIDTH*pNUM_TRIGGER_PULSES-1:0] wid_q, wid_d;
  logic                                        fired_q, fired_d;
  logic [CW-1:0]                               cap_cnt_q, cap_cnt_d;
  logic                                        cap_run_q, cap_run_d;
  logic                                        cap_pulse_q, cap_pulse_d;
  logic                                        trig_q, trig_d;
  logic                                        busy_q, busy_d;
  logic                                        accept_s;
  logic [pDELAY_WIDTH-1:0]                     d0_s;

  // Next-state logic: accept, fired flag, capture counter and trigger FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    num_last_d  = num_last_q;
    dly_d       = dly_q;
    wid_d       = wid_q;
    cap_cnt_d   = cap_cnt_q;
    cap_run_d   = cap_run_q;
    cap_pulse_d = 1'b0;
    d0_s        = sel_delay(I_trigger_delay, '0);

    accept_s = I_match & I_arm & ~fired_q & (state_q == ST_IDLE) & ~cap_run_q & ~cap_pulse_q;

    if (!I_arm) begin
      fired_d = 1'b0;
    end else if (accept_s) begin
      fired_d = 1'b1;
    end else begin
      fired_d = fired_q;
    end

    // Shadow the quasi-static configuration exactly once, on accept.
    if (accept_s) begin
      dly_d = I_trigger_delay;
      wid_d = I_trigger_width;
      if (I_num_triggers == '0) begin
        num_last_d = '0;
      end else if ({1'b0, I_num_triggers} > MAX_PULSES) begin
        num_last_d = MAX_LAST;
      end else begin
        num_last_d = I_num_triggers - IDX_ONE;
      end
    end else begin
      num_last_d = num_last_q;
    end

    // Capture path: pulse lands capture_delay+1 cycles after accept.
    if (accept_s) begin
      if (I_capture_delay == '0) begin
        cap_pulse_d = 1'b1;
        cap_run_d   = 1'b0;
        cap_cnt_d   = '0;
      end else begin
        cap_run_d = 1'b1;
        cap_cnt_d = I_capture_delay - CAP_ONE;
      end
    end else if (cap_run_q) begin
      if (cap_cnt_q == '0) begin
        cap_run_d   = 1'b0;
        cap_pulse_d = 1'b1;
      end else begin
        cap_cnt_d = cap_cnt_q - CAP_ONE;
      end
    end else begin
      cap_run_d = 1'b0;
    end

    // Trigger FSM. The first delay is taken straight from the inputs and
    // a zero delay jumps directly to PULSE so pulse 0 rises delay[0]+1
    // cycles after the accept cycle.
    case (state_q)
      ST_IDLE: begin
        if (accept_s && I_trigger_enable) begin
          idx_d = '0;
          if (d0_s == '0) begin
            state_d = ST_PULSE;
            cnt_d   = floor_m1(CNT_W'(sel_width(I_trigger_width, '0)));
          end else begin
            state_d = ST_DELAY;
            cnt_d   = CNT_W'(d0_s) - CNT_ONE;
          end
        end else begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      ST_DELAY: begin
        if (!I_trigger_enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = floor_m1(CNT_W'(sel_width(wid_q, idx_q)));
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (!I_trigger_enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          if (idx_q == num_last_q) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = ST_DELAY;
            idx_d   = idx_q + IDX_ONE;
            cnt_d   = floor_m1(CNT_W'(sel_delay(dly_q, idx_q + IDX_ONE)));
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    trig_d = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE) | cap_run_d | cap_pulse_d;
  end

  // State, shadow and output registers.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      num_last_q  <= '0;
      dly_q       <= '0;
      wid_q       <= '0;
      fired_q     <= 1'b0;
      cap_cnt_q   <= '0;
      cap_run_q   <= 1'b0;
      cap_pulse_q <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      num_last_q  <= num_last_d;
      dly_q       <= dly_d;
      wid_q       <= wid_d;
      fired_q     <= fired_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_run_q   <= cap_run_d;
      cap_pulse_q <= cap_pulse_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
    end
  end

  assign O_trigger              = trig_q;
  assign O_capture_enable_pulse = cap_pulse_q;
  assign O_busy                 = busy_q;
  assign O_pulse_index          = idx_q;

`ifdef PW_TRIG_MATCH_COUNT_EN
  logic        arm_q;
  logic [15:0] mcnt_q;
  logic [15:0] mdrop_q;

  // Saturating accepted/dropped match counters, cleared on arm rising edge.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q   <= 1'b0;
      mcnt_q  <= 16'h0000;
      mdrop_q <= 16'h0000;
    end else begin
      arm_q <= I_arm;
      if (I_arm && !arm_q) begin
        mcnt_q  <= 16'h0000;
        mdrop_q <= 16'h0000;
      end else begin
        if (accept_s && (mcnt_q != 16'hFFFF)) mcnt_q <= mcnt_q + 16'h0001;
        if (I_match && I_arm && !accept_s && (mdrop_q != 16'hFFFF)) mdrop_q <= mdrop_q + 16'h0001;
      end
    end
  end

  assign O_match_count   = mcnt_q;
  assign O_match_dropped = mdrop_q;
`endif

endmodule

// File: tb/tb_pw_trigger_gen.sv
// Self-checking bench for pw_trigger_gen: directed and randomized trains
// compared against a cycle-indexed waveform model built from pulse timing
// rules (delay/width/gap arithmetic), plus reset and re-arm scenarios.
module tb_pw_trigger_gen;
  localparam int NP = 8;
  localparam int NW = 4;
  localparam int DW = 24;
  localparam int WW = 24;
  localparam int CW = 18;

  logic              fe_clk = 1'b0;
  logic              reset_n;
  logic              I_arm;
  logic              I_trigger_enable;
  logic              I_match;
  logic [NW-1:0]     I_num_triggers;
  logic [DW*NP-1:0]  I_trigger_delay;
  logic [WW*NP-1:0]  I_trigger_width;
  logic [CW-1:0]     I_capture_delay;
  logic              O_trigger;
  logic              O_capture_enable_pulse;
  logic              O_busy;
  logic [NW-1:0]     O_pulse_index;
`ifdef PW_TRIG_MATCH_COUNT_EN
  logic [15:0]       O_match_count;
  logic [15:0]       O_match_dropped;
`endif

  int checks = 0;
  int errors = 0;
  int dly[NP];
  int wid[NP];
  int model_acc  = 0;
  int model_drop = 0;

  pw_trigger_gen dut (
    .fe_clk                 (fe_clk),
    .reset_n                (reset_n),
    .I_arm                  (I_arm),
    .I_trigger_enable       (I_trigger_enable),
    .I_match                (I_match),
    .I_num_triggers         (I_num_triggers),
    .I_trigger_delay        (I_trigger_delay),
    .I_trigger_width        (I_trigger_width),
    .I_capture_delay        (I_capture_delay),
    .O_trigger              (O_trigger),
    .O_capture_enable_pulse (O_capture_enable_pulse),
    .O_busy                 (O_busy),
    .O_pulse_index          (O_pulse_index)
`ifdef PW_TRIG_MATCH_COUNT_EN
    ,
    .O_match_count          (O_match_count),
    .O_match_dropped        (O_match_dropped)
`endif
  );

  always #5 fe_clk = ~fe_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
`ifdef PW_TRIG_MATCH_COUNT_EN
    chk({tag, "_match_count"}, {16'h0000, O_match_count}, model_acc);
    chk({tag, "_match_dropped"}, {16'h0000, O_match_dropped}, model_drop);
`endif
  endtask

  task automatic program_cfg(input int num, input int cd);
    for (int k = 0; k < NP; k++) begin
      I_trigger_delay[k*DW +: DW] = DW'(dly[k]);
      I_trigger_width[k*WW +: WW] = WW'(wid[k]);
    end
    I_num_triggers  = NW'(num);
    I_capture_delay = CW'(cd);
  endtask

  task automatic scramble_cfg();
    for (int k = 0; k < NP; k++) begin
      I_trigger_delay[k*DW +: DW] = DW'($urandom_range(0, 50));
      I_trigger_width[k*WW +: WW] = WW'($urandom_range(0, 50));
    end
    I_num_triggers  = NW'($urandom_range(0, 15));
    I_capture_delay = CW'($urandom_range(0, 90));
  endtask

  task automatic rearm();
    I_arm = 1'b0;
    cycle();
    I_arm = 1'b1;
    cycle();
    model_acc  = 0;
    model_drop = 0;
    chk_counts("rearm");
  endtask

  // Fire one accepted match and compare every cycle against the model.
  task automatic run_train(input string name, input int num, input int cd, input bit en,
                           input int abort_at, input int stray_at);
    bit exp_trig[300];
    int exp_idx[300];
    int ldly[NP];
    int lwid[NP];
    int nt, cur, train_end, last, gap_start, w;
    for (int k = 0; k < NP; k++) begin ldly[k] = dly[k]; lwid[k] = wid[k]; end
    for (int j = 0; j < 300; j++) begin exp_trig[j] = 1'b0; exp_idx[j] = 0; end
    nt = (num == 0) ? 1 : ((num > NP) ? NP : num);
    train_end = 0;
    if (en) begin
      cur = 1 + ldly[0];
      for (int i = 0; i < nt; i++) begin
        if (i > 0) begin
          gap_start = cur;
          cur = cur + ((ldly[i] == 0) ? 1 : ldly[i]);
        end else begin
          gap_start = 1;
        end
        for (int j = gap_start; j < cur; j++) exp_idx[j] = i;
        w = (lwid[i] == 0) ? 1 : lwid[i];
        for (int j = cur; j < cur + w; j++) begin exp_trig[j] = 1'b1; exp_idx[j] = i; end
        cur = cur + w;
      end
      train_end = cur - 1;
      if (abort_at >= 1 && abort_at < train_end) begin
        for (int j = abort_at + 1; j < 300; j++) begin exp_trig[j] = 1'b0; exp_idx[j] = 0; end
        train_end = abort_at;
      end
    end
    last = ((train_end > cd + 1) ? train_end : cd + 1) + 2;

    program_cfg(num, cd);
    I_trigger_enable = en;
    I_match = 1'b1;
    model_acc++;
    cycle();
    I_match = 1'b0;
    scramble_cfg();
    for (int j = 1; j <= last; j++) begin
      chk($sformatf("%s_trig@%0d", name, j), {31'd0, O_trigger}, exp_trig[j]);
      chk($sformatf("%s_cap@%0d", name, j), {31'd0, O_capture_enable_pulse}, (j == cd + 1) ? 1 : 0);
      chk($sformatf("%s_busy@%0d", name, j), {31'd0, O_busy},
          ((j <= train_end) || (j <= cd + 1)) ? 1 : 0);
      chk($sformatf("%s_idx@%0d", name, j), {28'd0, O_pulse_index}, exp_idx[j]);
      if (j == abort_at) I_trigger_enable = 1'b0;
      I_match = (j == stray_at);
      if (j == stray_at) model_drop++;
      cycle();
    end
    I_match = 1'b0;
    I_trigger_enable = 1'b1;
  endtask

  // Match while armed but already fired: must be ignored entirely.
  task automatic idle_match();
    I_match = 1'b1;
    model_drop++;
    cycle();
    I_match = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("idle_trig@%0d", j), {31'd0, O_trigger}, 0);
      chk($sformatf("idle_busy@%0d", j), {31'd0, O_busy}, 0);
      chk($sformatf("idle_cap@%0d", j), {31'd0, O_capture_enable_pulse}, 0);
      cycle();
    end
  endtask

  initial begin
    int num, cd, ab, st;
    reset_n = 1'b0;
    I_arm = 1'b0;
    I_trigger_enable = 1'b1;
    I_match = 1'b0;
    for (int k = 0; k < NP; k++) begin dly[k] = 0; wid[k] = 0; end
    program_cfg(0, 0);
    #2;
    chk("rst_trig", {31'd0, O_trigger}, 0);
    chk("rst_cap", {31'd0, O_capture_enable_pulse}, 0);
    chk("rst_busy", {31'd0, O_busy}, 0);
    chk("rst_idx", {28'd0, O_pulse_index}, 0);
    chk_counts("rst");
    cycle();
    reset_n = 1'b1;
    cycle();
    I_arm = 1'b1;
    cycle();
    cycle();

    // Single pulse, plus a busy-time match and a post-completion match.
    dly = '{5, 0, 0, 0, 0, 0, 0, 0};
    wid = '{3, 0, 0, 0, 0, 0, 0, 0};
    run_train("t1", 1, 10, 1'b1, -1, 3);
    idle_match();
    chk_counts("t1");
    rearm();

    // Three pulses with zero delay/width fields.
    dly = '{0, 4, 0, 0, 0, 0, 0, 0};
    wid = '{2, 0, 1, 0, 0, 0, 0, 0};
    run_train("t2", 3, 20, 1'b1, -1, -1);
    rearm();

    // Enable drops mid-train; capture still fires.
    run_train("t4", 3, 20, 1'b1, 7, -1);
    rearm();

    // Enable low at accept: capture only.
    run_train("noen", 5, 6, 1'b0, -1, 2);
    chk_counts("noen");
    rearm();

    // Randomized trains, including num 0 and num above the maximum.
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < NP; k++) begin
        dly[k] = $urandom_range(0, 6);
        wid[k] = $urandom_range(0, 5);
      end
      num = (r == 0) ? 0 : ((r == 1) ? 15 : $urandom_range(0, 15));
      cd  = $urandom_range(0, 60);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
      st  = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(1, 20);
      run_train($sformatf("rnd%0d", r), num, cd, 1'b1, ab, st);
      chk_counts("rnd");
      rearm();
    end

    // Asynchronous reset in the middle of a pulse.
    dly = '{2, 0, 0, 0, 0, 0, 0, 0};
    wid = '{10, 0, 0, 0, 0, 0, 0, 0};
    program_cfg(1, 30);
    I_match = 1'b1;
    cycle();
    I_match = 1'b0;
    repeat (4) cycle();
    chk("prerst_trig", {31'd0, O_trigger}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    model_acc  = 0;
    model_drop = 0;
    chk("midrst_trig", {31'd0, O_trigger}, 0);
    chk("midrst_busy", {31'd0, O_busy}, 0);
    chk("midrst_cap", {31'd0, O_capture_enable_pulse}, 0);
    chk("midrst_idx", {28'd0, O_pulse_index}, 0);
    chk_counts("midrst");
    cycle();
    reset_n = 1'b1;
    cycle();
    cycle();
    dly = '{1, 2, 0, 0, 0, 0, 0, 0};
    wid = '{2, 3, 0, 0, 0, 0, 0, 0};
    run_train("postrst", 2, 3, 1'b1, -1, -1);
    chk_counts("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
